// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit; define MULDIV_FAST_MUL_EN for single-cycle multiplies
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t      state_q;
  logic        busy_q, done_q, neg_q;
  logic [2:0]  op_q;
  logic [4:0]  cnt_q;
  logic [31:0] result_q, y_q;
  logic [63:0] acc_q, acc_d, prod;
  logic        a_sgn, b_sgn, sa, sb, is_rem, special;
  logic [31:0] a_mag, b_mag, special_res, quo, rem, fin;
  logic [32:0] mul_sum, div_rem, div_diff;
`ifdef MULDIV_FAST_MUL_EN
  logic [63:0] fast_prod;
  logic [31:0] fast_res;
`endif
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  // operand decode at capture: sign handling, magnitudes and divide special cases
  always_comb begin
    a_sgn       = op == 3'b001 || op == 3'b010 || op == 3'b100 || op == 3'b110;
    b_sgn       = op == 3'b001 || op == 3'b100 || op == 3'b110;
    sa          = a_sgn & a[31];
    sb          = b_sgn & b[31];
    a_mag       = sa ? -a : a;
    b_mag       = sb ? -b : b;
    is_rem      = op[2] & op[1];
    special     = op[2] && (b == 32'd0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    special_res = b == 32'd0 ? (is_rem ? a : 32'hFFFF_FFFF) : (is_rem ? 32'd0 : 32'h8000_0000);
  end
`ifdef MULDIV_FAST_MUL_EN
  // sign-extended operands give the 33x33 signed product in the low 64 bits
  always_comb begin
    fast_prod = {{32{sa}}, a} * {{32{sb}}, b};
    fast_res  = op[1:0] == 2'b00 ? fast_prod[31:0] : fast_prod[63:32];
  end
`endif
  // one iteration: shift-add multiply on {hi, multiplier}, restoring divide on {rem, quotient}
  always_comb begin
    mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, y_q} : 33'd0);
    div_rem  = {acc_q[63:32], acc_q[31]};
    div_diff = div_rem - {1'b0, y_q};
    acc_d    = op_q[2] ? {div_diff[32] ? div_rem[31:0] : div_diff[31:0], acc_q[30:0], ~div_diff[32]}
                       : {mul_sum, acc_q[31:1]};
    prod     = neg_q ? -acc_d : acc_d;
    quo      = neg_q ? -acc_d[31:0] : acc_d[31:0];
    rem      = neg_q ? -acc_d[63:32] : acc_d[63:32];
    fin      = op_q[2] ? (op_q[1] ? rem : quo) : (op_q[1:0] == 2'b00 ? prod[31:0] : prod[63:32]);
  end
  // control FSM with registered busy/done/result; flush aborts without touching result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= 32'd0;
      cnt_q    <= 5'd0;
      acc_q    <= 64'd0;
      y_q      <= 32'd0;
      op_q     <= 3'd0;
      neg_q    <= 1'b0;
    end else if (flush) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          op_q  <= op;
          neg_q <= is_rem ? sa : sa ^ sb;
          acc_q <= {32'd0, a_mag};
          y_q   <= b_mag;
          cnt_q <= 5'd0;
          if (special) begin
            state_q  <= DONE;
            done_q   <= 1'b1;
            result_q <= special_res;
`ifdef MULDIV_FAST_MUL_EN
          end else if (!op[2]) begin
            state_q  <= DONE;
            done_q   <= 1'b1;
            result_q <= fast_res;
`endif
          end else begin
            state_q <= RUN;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_q  <= DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            result_q <= fin;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed checks of muldiv_unit results, latency, special cases, flush and reset
module tb_muldiv_unit;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 0;
`else
  localparam int MUL_LAT = 32;
`endif
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, flush = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = 32'd0, b = 32'd0;
  logic        busy, done;
  logic [31:0] result;
  int checks = 0, errors = 0;
  muldiv_unit dut (.clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
                   .flush(flush), .busy(busy), .done(done), .result(result));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic wait_done(output int lat, output int bcnt);
    lat = 0;
    bcnt = 0;
    while (!done && lat < 40) begin
      if (busy) bcnt++;
      @(negedge clk);
      lat++;
    end
  endtask
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic run(input string tag, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] exp, input int exp_lat);
    int lat, bcnt;
    issue(o, x, y);
    wait_done(lat, bcnt);
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " busy cycles"}, bcnt, exp_lat == 0 ? 0 : 32);
    check({tag, " result"}, result, exp);
    @(negedge clk);
    check({tag, " done pulse width"}, {31'd0, done}, 32'd0);
  endtask
  initial begin
    int lat, bcnt, seen;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle busy", {31'd0, busy}, 32'd0);
      check("idle done", {31'd0, done}, 32'd0);
      check("idle result", result, 32'd0);
    end
    run("MUL 7*6", 3'b000, 32'd7, 32'd6, 32'd42, MUL_LAT);
    run("MULH min*min", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT);
    run("MULHU max*max", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
    run("MULHSU -1*2", 3'b010, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, MUL_LAT);
    run("MUL -3*5", 3'b000, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, MUL_LAT);
    run("DIV -7/2", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32);
    run("REM -7%2", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32);
    run("DIVU 100/7", 3'b101, 32'd100, 32'd7, 32'd14, 32);
    run("REMU 100%7", 3'b111, 32'd100, 32'd7, 32'd2, 32);
    run("DIV 5/0", 3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 0);
    run("REMU 5%0", 3'b111, 32'd5, 32'd0, 32'd5, 0);
    run("DIV ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    run("REM ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0);
    run("REMU 100%7 again", 3'b111, 32'd100, 32'd7, 32'd2, 32);
    issue(3'b101, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush busy", {31'd0, busy}, 32'd0);
    check("flush done", {31'd0, done}, 32'd0);
    check("flush result", result, 32'd2);
    run("DIVU after flush", 3'b101, 32'd100, 32'd7, 32'd14, 32);
    issue(3'b110, 32'hFFFF_FFF9, 32'd2);
    repeat (3) @(negedge clk);
    op = 3'b000; a = 32'd3; b = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bcnt);
    check("start ignored done", {31'd0, done}, 32'd1);
    check("start ignored result", result, 32'hFFFF_FFFF);
    @(negedge clk);
    op = 3'b101; a = 32'd9; b = 32'd0; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      if (done || busy) seen++;
      @(negedge clk);
    end
    check("flush+start no capture", seen, 0);
    check("flush+start result", result, 32'hFFFF_FFFF);
    issue(3'b101, 32'd100, 32'd7);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async rst busy", {31'd0, busy}, 32'd0);
    check("async rst result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run("DIVU after rst", 3'b101, 32'd100, 32'd7, 32'd14, 32);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the EX stage, in parallel with the ALU.
- Takes the same forwarded rs1/rs2 operands as the ALU and selects the operation by funct3.
- Returns a registered 32-bit result with a done pulse; the EX/MEM mux selects it instead of the ALU result.
- Pipeline control stalls IF/ID/EX from the cycle start is asserted until done.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous active-high reset
- start  input  1  launch request, sampled in IDLE only
- op  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- a  input  32  rs1 operand (dividend / multiplicand)
- b  input  32  rs2 operand (divisor / multiplier)
- flush  input  1  abort the in-flight operation (branch mispredict/trap)
- busy  output  1  registered; high only in RUN
- done  output  1  registered; one-cycle pulse, result valid
- result  output  32  registered; holds its value until the next accepted start

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-high.
- Reset values: state=IDLE, busy=0, done=0, result=0, iteration counter=0, internal accumulators=0.
- States:
  - IDLE -> RUN when start=1 and flush=0.
  - IDLE -> DONE directly for divide special cases.
  - RUN -> DONE after the 32nd iteration.
  - DONE -> IDLE unconditionally after one cycle.
- Capture (edge N, IDLE, start=1): latch op and sign flags. Convert operands to magnitudes:
  - a is signed for MULH, MULHSU, DIV, REM.
  - b is signed for MULH, DIV, REM.
  - Record the result sign: product = sa^sb; quotient = sa^sb; remainder = sign of a.
- Multiply: radix-2 shift-add, 64-bit unsigned product, one bit per cycle.
  - Result after sign fix: MUL = low 32 bits; MULH/MULHSU/MULHU = high 32 bits.
  - Negation is a two's-complement of the full 64 bits.
- Divide: restoring, one quotient bit per cycle, on 32-bit magnitudes.
  - Apply sign correction at completion.
- Latency: iterations occur at edges N+1..N+32. At edge N+32, result is written and state=DONE. done is high for exactly the cycle after edge N+32.
- Special cases, decided at edge N, which go straight to DONE (done in the cycle after N, busy never asserted):
  - b=0, DIV/DIVU: result=0xFFFFFFFF.
  - b=0, REM/REMU: result=a.
  - DIV with a=0x80000000, b=0xFFFFFFFF: result=0x80000000.
  - REM with the same operands: result=0.
- start while RUN or DONE: ignored, no re-capture.
- flush in any state: next edge goes to IDLE, busy=0, done=0, result unchanged.
- flush and start in the same IDLE cycle: flush wins, nothing captured.
- flush in the same cycle as the final iteration: flush wins, no done, result unchanged.
- rst mid-operation: immediate return to reset values, independent of clk.
- No exceptions are raised; all arithmetic is modulo 2^32 except the internal 64-bit product.

Optional Feature:
- MULDIV_FAST_MUL_EN defined:
  - MUL/MULH/MULHSU/MULHU use a combinational 33x33 signed product.
  - At edge N, result is written and state=DONE; done is high in the cycle after N; busy is never asserted for multiplies.
  - Divides are unchanged.
- Undefined: all multiplies take the 32-iteration path. Results are bit-identical in both builds.

Test Plan:
- Reset, then idle 5 cycles -> busy=0, done=0, result=0 throughout.
- start, MUL a=7 b=6 -> busy high 32 cycles, done pulse 32 cycles after the capture edge, result=42. With MULDIV_FAST_MUL_EN -> done 1 cycle after capture, result=42.
- Multiply high halves:
  - MULH a=0x80000000 b=0x80000000 -> 0x40000000.
  - MULHU a=0xFFFFFFFF b=0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU a=0xFFFFFFFF b=2 -> 0xFFFFFFFF.
- Signed divide/remainder:
  - DIV a=-7 b=2 -> 0xFFFFFFFD (-3).
  - REM a=-7 b=2 -> 0xFFFFFFFF (-1).
  - DIVU a=100 b=7 -> 14.
  - REMU a=100 b=7 -> 2.
- Special cases:
  - DIV a=5 b=0 -> 0xFFFFFFFF.
  - REMU a=5 b=0 -> 5.
  - DIV a=0x80000000 b=-1 -> 0x80000000.
  - All complete with done 1 cycle after capture, busy never high.
- flush at iteration 10 of DIVU 100/7 -> IDLE next edge, no done, result keeps prior value. A new start is accepted the cycle after; start asserted while busy is ignored (result reflects the first operands only).
